cut_multi_harness: RTL and testbench

Parametrised successor of the single-CUT test harness. Sits between autotest_module and up to NUM_CUTS circuit-under-test instances (e.g. several spongent variants). It selects one CUT per run, sequences its reset, broadcasts the input word and measures latency from reset release to end flag. It also captures the selected CUT's output and flags timeouts, so hash latency is measured in hardware.

---
 rtl/harness_pkg.sv | 23 ++
 rtl/harness_out_mux.sv | 41 ++++
 rtl/cut_multi_harness.sv | 188 ++++++++++++++++++
 tb/tb_cut_multi_harness.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harness_pkg.sv
// Shared types and spongent-88 default constants for the multi-CUT test harness.
package harness_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_RUN,
      ST_DONE,
      ST_TOUT
   } harness_state_t;

   localparam int SPONGENT88_IN_WIDTH  = 64;
   localparam int SPONGENT88_OUT_WIDTH = 88;
   localparam int DEFAULT_CNT_WIDTH    = 32;
   localparam int DEFAULT_RST_CYCLES   = 4;
   localparam int DEFAULT_TIMEOUT      = 1048576;

   // Width able to hold values 0..n-1, never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/harness_out_mux.sv
// Registered NUM_CUTS:1 selector for the captured CUT output.
// Clear takes priority over capture so an aborted run leaves zero behind.
module harness_out_mux #(
   parameter int NUM_CUTS  = 4,
   parameter int OUT_WIDTH = 88,
   parameter int SEL_W     = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_capture,
   input  logic                          i_clear,
   input  logic [SEL_W-1:0]              i_sel,
   input  logic [NUM_CUTS*OUT_WIDTH-1:0] i_data,
   output logic [OUT_WIDTH-1:0]          o_dout
);

   logic [OUT_WIDTH-1:0] w_slice;
   logic [OUT_WIDTH-1:0] r_dout;

   always_comb begin
      w_slice = '0;
      for (int k = 0; k < NUM_CUTS; k++) begin
         if (i_sel == SEL_W'(k)) begin
            w_slice = i_data[k*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dout <= '0;
      end else if (i_clear) begin
         r_dout <= '0;
      end else if (i_capture) begin
         r_dout <= w_slice;
      end
   end

   assign o_dout = r_dout;

endmodule

// File: rtl/cut_multi_harness.sv
// Selects one of NUM_CUTS circuits under test, sequences its reset, and
// measures cycles from reset release to its end flag, with timeout abort.
module cut_multi_harness
   import harness_pkg::*;
#(
   parameter int  NUM_CUTS   = 4,
   parameter int  IN_WIDTH   = SPONGENT88_IN_WIDTH,
   parameter int  OUT_WIDTH  = SPONGENT88_OUT_WIDTH,
   parameter int  CNT_WIDTH  = DEFAULT_CNT_WIDTH,
   parameter int  RST_CYCLES = DEFAULT_RST_CYCLES,
   parameter int  TIMEOUT    = DEFAULT_TIMEOUT,
   localparam int SEL_W      = sel_width(NUM_CUTS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [SEL_W-1:0]              sel,
   input  logic [IN_WIDTH-1:0]           din,
   output logic                          busy,
   output logic                          done,
   output logic                          timeout,
   output logic                          err,
   output logic [CNT_WIDTH-1:0]          cycles,
   output logic [OUT_WIDTH-1:0]          dout,
   output logic [NUM_CUTS-1:0]           cut_rst,
   output logic [IN_WIDTH-1:0]           cut_din,
   input  logic [NUM_CUTS*OUT_WIDTH-1:0] cut_dout,
   input  logic [NUM_CUTS-1:0]           cut_end
);

   localparam int                   RCNT_W      = sel_width(RST_CYCLES);
   localparam logic [RCNT_W-1:0]    RCNT_INIT   = RCNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_C   = CNT_WIDTH'(TIMEOUT);
   localparam logic [SEL_W:0]       NUM_CUTS_X  = (SEL_W + 1)'(NUM_CUTS);

   if (RST_CYCLES < 1) begin : g_badRstCycles
      $error("cut_multi_harness: RST_CYCLES must be at least 1");
   end
   if ((TIMEOUT < 1) || ((CNT_WIDTH < 31) && (TIMEOUT >= (1 << CNT_WIDTH)))) begin : g_badTimeout
      $error("cut_multi_harness: TIMEOUT must fit below 2**CNT_WIDTH");
   end

   harness_state_t         r_state;
   harness_state_t         w_next;
   logic [SEL_W-1:0]       r_sel;
   logic [IN_WIDTH-1:0]    r_cutDin;
   logic [RCNT_W-1:0]      r_rcnt;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [CNT_WIDTH-1:0]   r_cycles;
   logic                   r_done;
   logic                   r_tout;
   logic                   r_err;
   logic [NUM_CUTS-1:0]    r_cutRst;

   logic [NUM_CUTS-1:0]    w_selOneHot;
   logic [CNT_WIDTH-1:0]   w_cntInc;
   logic                   w_selBad;
   logic                   w_endSel;
   logic                   w_accept;
   logic                   w_badStart;
   logic                   w_finish;
   logic                   w_abort;

   always_comb begin
      w_selOneHot = '0;
      for (int k = 0; k < NUM_CUTS; k++) begin
         if (r_sel == SEL_W'(k)) begin
            w_selOneHot[k] = 1'b1;
         end
      end
   end

   assign w_selBad = ({1'b0, sel} >= NUM_CUTS_X);
   assign w_endSel = |(cut_end & w_selOneHot);
   assign w_cntInc = r_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // End flag wins over the timeout when both land on the same RUN cycle.
   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_badStart = 1'b0;
      w_finish   = 1'b0;
      w_abort    = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE, ST_TOUT: begin
            if (start) begin
               if (w_selBad) begin
                  w_badStart = 1'b1;
               end else begin
                  w_accept = 1'b1;
                  w_next   = ST_RESET;
               end
            end
         end
         ST_RESET: begin
            if (r_rcnt == '0) begin
               w_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_endSel) begin
               w_finish = 1'b1;
               w_next   = ST_DONE;
            end else if (w_cntInc == TIMEOUT_C) begin
               w_abort = 1'b1;
               w_next  = ST_TOUT;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sel    <= '0;
         r_cutDin <= '0;
         r_rcnt   <= '0;
         r_cnt    <= '0;
         r_cycles <= '0;
         r_done   <= 1'b0;
         r_tout   <= 1'b0;
         r_err    <= 1'b0;
         r_cutRst <= '1;
      end else begin
         r_err <= w_badStart;
         if (w_accept) begin
            r_sel    <= sel;
            r_cutDin <= din;
            r_done   <= 1'b0;
            r_tout   <= 1'b0;
            r_rcnt   <= RCNT_INIT;
         end
         if (r_state == ST_RESET) begin
            if (r_rcnt == '0) begin
               r_cnt <= '0;
            end else begin
               r_rcnt <= r_rcnt - 1'b1;
            end
         end
         if ((r_state == ST_RUN) && !w_endSel) begin
            r_cnt <= w_cntInc;
         end
         if (w_finish) begin
            r_cycles <= w_cntInc;
            r_done   <= 1'b1;
         end
         if (w_abort) begin
            r_cycles <= TIMEOUT_C;
            r_tout   <= 1'b1;
         end
         // Only the selected CUT is released, and only while in RUN.
         r_cutRst <= (w_next == ST_RUN) ? ~w_selOneHot : '1;
      end
   end

   harness_out_mux #(
      .NUM_CUTS  (NUM_CUTS),
      .OUT_WIDTH (OUT_WIDTH),
      .SEL_W     (SEL_W)
   ) u_outMux (
      .clk       (clk),
      .rst       (rst),
      .i_capture (w_finish),
      .i_clear   (w_abort),
      .i_sel     (r_sel),
      .i_data    (cut_dout),
      .o_dout    (dout)
   );

   assign busy    = (r_state == ST_RESET) || (r_state == ST_RUN);
   assign done    = r_done;
   assign timeout = r_tout;
   assign err     = r_err;
   assign cycles  = r_cycles;
   assign cut_rst = r_cutRst;
   assign cut_din = r_cutDin;

endmodule

// File: tb/tb_cut_multi_harness.sv
// Self-checking bench for cut_multi_harness with three behavioural CUT models.
module tb_cut_multi_harness;

   localparam int NUM  = 3;
   localparam int INW  = 64;
   localparam int OUTW = 88;
   localparam int CNTW = 32;
   localparam int RSTC = 4;
   localparam int TOUT = 16;

   typedef logic [127:0] wide_t;

   typedef struct {
      logic [1:0]  sel;
      logic [63:0] din;
      int          lat;
      bit          frc;
      bit          mid;
      bit          expDone;
      bit          expTout;
      logic [31:0] expCycles;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [1:0]           sel;
   logic [INW-1:0]       din;
   logic                 busy, done, timeout, err;
   logic [CNTW-1:0]      cycles;
   logic [OUTW-1:0]      dout;
   logic [NUM-1:0]       cut_rst;
   logic [INW-1:0]       cut_din;
   logic [NUM*OUTW-1:0]  cut_dout;
   logic [NUM-1:0]       cut_end;

   logic [OUTW-1:0] cutVal [NUM];
   int              latency [NUM];
   bit              forceEnd [NUM];
   int              runCnt [NUM];

   int          checks = 0;
   int          errors = 0;
   int          activeSel = 0;
   bit          monitorOn = 1'b0;
   bit          lastDone = 1'b0;
   bit          lastTout = 1'b0;
   logic [31:0] lastCyc = '0;
   logic [87:0] lastDout = '0;

   cut_multi_harness #(
      .NUM_CUTS   (NUM),
      .IN_WIDTH   (INW),
      .OUT_WIDTH  (OUTW),
      .CNT_WIDTH  (CNTW),
      .RST_CYCLES (RSTC),
      .TIMEOUT    (TOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sel      (sel),
      .din      (din),
      .busy     (busy),
      .done     (done),
      .timeout  (timeout),
      .err      (err),
      .cycles   (cycles),
      .dout     (dout),
      .cut_rst  (cut_rst),
      .cut_din  (cut_din),
      .cut_dout (cut_dout),
      .cut_end  (cut_end)
   );

   always #5 clk = ~clk;

   assign cut_dout = {cutVal[2], cutVal[1], cutVal[0]};

   // CUT model: counts cycles out of reset and raises end after its latency.
   always @(posedge clk) begin
      for (int k = 0; k < NUM; k++) begin
         runCnt[k] <= cut_rst[k] ? 0 : runCnt[k] + 1;
      end
   end

   always_comb begin
      cut_end = '0;
      for (int k = 0; k < NUM; k++) begin
         cut_end[k] = forceEnd[k] ||
                      (!cut_rst[k] && (latency[k] != 0) && (runCnt[k] + 1 >= latency[k]));
      end
   end

   task automatic checkOutput(input string name, input wide_t actual, input wide_t expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // A CUT may be released only when it is the active one and a run is in progress.
   always @(negedge clk) begin
      if (monitorOn && rst) begin
         bit bad;
         bad = 1'b0;
         for (int k = 0; k < NUM; k++) begin
            if (!cut_rst[k] && ((k != activeSel) || !busy)) bad = 1'b1;
         end
         checkOutput("cutRstIdle", wide_t'(bad), wide_t'(0));
      end
   end

   task automatic refModel(input int lat, input bit frc,
                           output bit eDone, output bit eTout, output logic [31:0] eCyc);
      if (frc) begin
         eDone = 1'b1; eTout = 1'b0; eCyc = 32'd1;
      end else if ((lat == 0) || (lat > TOUT)) begin
         eDone = 1'b0; eTout = 1'b1; eCyc = 32'(TOUT);
      end else begin
         eDone = 1'b1; eTout = 1'b0; eCyc = 32'(lat);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] s, input logic [63:0] d);
      start = 1'b1;
      sel   = s;
      din   = d;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic runAndCheck(input string name, input logic [1:0] s, input logic [63:0] d,
                              input int lat, input bit frc, input bit mid);
      bit          eDone, eTout;
      logic [31:0] eCyc;
      logic [87:0] eDout;
      int          n;
      refModel(lat, frc, eDone, eTout, eCyc);
      for (int k = 0; k < NUM; k++) begin
         cutVal[k] = {24'($urandom), 32'($urandom), 32'($urandom)};
         if (k == int'(s)) begin
            forceEnd[k] = frc;
            latency[k]  = lat;
         end else begin
            forceEnd[k] = 1'($urandom_range(0, 1));
            latency[k]  = $urandom_range(1, 3);
         end
      end
      eDout = eDone ? cutVal[s] : '0;
      activeSel = int'(s);
      applyStimulus(s, d);
      checkOutput({name, "_busy"}, wide_t'(busy), wide_t'(1));
      checkOutput({name, "_doneClr"}, wide_t'(done), wide_t'(0));
      checkOutput({name, "_toutClr"}, wide_t'(timeout), wide_t'(0));
      checkOutput({name, "_cutDin"}, wide_t'(cut_din), wide_t'(d));
      n = 0;
      while (cut_rst[s] && (n < 50)) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_rstLen"}, wide_t'(n), wide_t'(RSTC));
      n = 0;
      if (mid) begin
         start = 1'b1;
         sel   = (s == 2'd0) ? 2'd1 : 2'd0;
         din   = ~d;
         @(negedge clk);
         start = 1'b0;
         n = 1;
      end
      while (!(done || timeout) && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_runLen"}, wide_t'(n), wide_t'(eCyc));
      checkOutput({name, "_done"}, wide_t'(done), wide_t'(eDone));
      checkOutput({name, "_timeout"}, wide_t'(timeout), wide_t'(eTout));
      checkOutput({name, "_cycles"}, wide_t'(cycles), wide_t'(eCyc));
      checkOutput({name, "_dout"}, wide_t'(dout), wide_t'(eDout));
      checkOutput({name, "_busyEnd"}, wide_t'(busy), wide_t'(0));
      checkOutput({name, "_cutDinHeld"}, wide_t'(cut_din), wide_t'(d));
      lastDone = eDone;
      lastTout = eTout;
      lastCyc  = eCyc;
      lastDout = eDout;
      for (int k = 0; k < NUM; k++) forceEnd[k] = 1'b0;
   endtask

   task automatic checkErr(input string name);
      applyStimulus(2'd3, {$urandom, $urandom});
      checkOutput({name, "_errPulse"}, wide_t'(err), wide_t'(1));
      checkOutput({name, "_errBusy"}, wide_t'(busy), wide_t'(0));
      checkOutput({name, "_errDone"}, wide_t'(done), wide_t'(lastDone));
      checkOutput({name, "_errTout"}, wide_t'(timeout), wide_t'(lastTout));
      @(negedge clk);
      checkOutput({name, "_errLow"}, wide_t'(err), wide_t'(0));
      checkOutput({name, "_errCycles"}, wide_t'(cycles), wide_t'(lastCyc));
      checkOutput({name, "_errDout"}, wide_t'(dout), wide_t'(lastDout));
   endtask

   initial begin
      vec_t vecs [8];
      vecs[0] = '{2'd2, 64'hDEADBEEF_01234567, 10, 1'b0, 1'b0, 1'b1, 1'b0, 32'd10};
      vecs[1] = '{2'd1, 64'h1111_2222_3333_4444, 12, 1'b0, 1'b1, 1'b1, 1'b0, 32'd12};
      vecs[2] = '{2'd0, 64'h0F0F_0F0F_F0F0_F0F0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3};
      vecs[3] = '{2'd2, 64'hA5A5_5A5A_0000_FFFF, 5, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1};
      vecs[4] = '{2'd1, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd16};
      vecs[5] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 16, 1'b0, 1'b0, 1'b1, 1'b0, 32'd16};
      vecs[6] = '{2'd1, 64'h8000_0000_0000_0001, 17, 1'b0, 1'b0, 1'b0, 1'b1, 32'd16};
      vecs[7] = '{2'd0, 64'h0000_0000_0000_0000, 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1};

      for (int k = 0; k < NUM; k++) begin
         cutVal[k] = '0; latency[k] = 0; forceEnd[k] = 1'b0;
      end
      start = 1'b0; sel = '0; din = '0;
      rst = 1'b1;
      #3 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_busy", wide_t'(busy), wide_t'(0));
      checkOutput("rst_done", wide_t'(done), wide_t'(0));
      checkOutput("rst_timeout", wide_t'(timeout), wide_t'(0));
      checkOutput("rst_err", wide_t'(err), wide_t'(0));
      checkOutput("rst_cycles", wide_t'(cycles), wide_t'(0));
      checkOutput("rst_dout", wide_t'(dout), wide_t'(0));
      checkOutput("rst_cutDin", wide_t'(cut_din), wide_t'(0));
      checkOutput("rst_cutRst", wide_t'(cut_rst), wide_t'(3'b111));
      rst = 1'b1;
      monitorOn = 1'b1;
      @(negedge clk);

      checkErr("idleErr");

      for (int i = 0; i < 8; i++) begin
         bit          eDone, eTout;
         logic [31:0] eCyc;
         refModel(vecs[i].lat, vecs[i].frc, eDone, eTout, eCyc);
         checkOutput($sformatf("vec%0d_model", i), wide_t'({eDone, eTout, eCyc}),
                     wide_t'({vecs[i].expDone, vecs[i].expTout, vecs[i].expCycles}));
         runAndCheck($sformatf("vec%0d", i), vecs[i].sel, vecs[i].din,
                     vecs[i].lat, vecs[i].frc, vecs[i].mid);
         if (i == 0) checkErr("doneErr");
         if (i == 4) checkErr("toutErr");
      end

      // Reset pulse in the middle of a run that would otherwise time out.
      for (int k = 0; k < NUM; k++) forceEnd[k] = 1'b0;
      latency[1] = 0;
      activeSel = 1;
      applyStimulus(2'd1, 64'hCAFE_F00D_1234_5678);
      repeat (6) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("midRst_busy", wide_t'(busy), wide_t'(0));
      checkOutput("midRst_cutRst", wide_t'(cut_rst), wide_t'(3'b111));
      checkOutput("midRst_cycles", wide_t'(cycles), wide_t'(0));
      checkOutput("midRst_dout", wide_t'(dout), wide_t'(0));
      checkOutput("midRst_done", wide_t'(done), wide_t'(0));
      checkOutput("midRst_cutDin", wide_t'(cut_din), wide_t'(0));
      @(negedge clk);
      rst = 1'b1;
      lastDone = 1'b0; lastTout = 1'b0; lastCyc = '0; lastDout = '0;
      @(negedge clk);
      runAndCheck("afterRst", 2'd2, 64'h7777_8888_9999_AAAA, 7, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         logic [1:0] s;
         int         lat;
         bit         frc;
         s   = 2'($urandom_range(0, NUM - 1));
         lat = $urandom_range(0, 20);
         frc = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 4) == 0) checkErr($sformatf("rnd%0d", i));
         runAndCheck($sformatf("rnd%0d", i), s, {$urandom, $urandom}, lat, frc,
                     (lat >= 2) && !frc && ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
